digit_scan_mux: RTL and testbench
=================================

# digit_scan_mux

Parametrised, registered N-channel time-multiplexing selector for the clock's multi-digit display. It replaces the fixed 4:1 combinational select with a channel scanner. The scanner cycles through N_CH packed W-bit inputs at a programmable rate and inserts a blanking gap on every channel change to stop ghosting. It also supports a manual-select mode. It sits between the time/date digit registers and the 7-segment decoder and anode drivers.

## Interface
- N_CH, 4: number of input channels, ≥2; need not be a power of two
- W, 4: width of each channel word
- DIV, 50000: SHOW duration per channel, in clk cycles, ≥1
- BLANK_CYC, 2: blanking duration per channel change, in cycles, ≥0
- SW (localparam): max(1, clog2(N_CH)), the index width
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scanner enable; 0 forces IDLE
- mode  in  1  0 = auto scan, 1 = manual select
- sel_manual  in  SW  requested channel in manual mode
- data_in  in  N_CH*W  packed channel words; channel k occupies bits [k*W +: W]
- blank_mask  in  N_CH  1 suppresses that channel's enable; data is still output
- data_out  out  W  registered word of the current channel
- ch_en  out  N_CH  registered one-hot enable of the current channel
- idx  out  SW  current channel index
- frame_tick  out  1  one-cycle pulse on wrap from N_CH-1 to 0

## Operation
- FSM states: IDLE, SHOW, BLANK.
- Reset values: state IDLE, idx 0, prescaler 0, data_out 0, ch_en 0, frame_tick 0.
- IDLE:
  - ch_en = 0, data_out = 0, prescaler held at 0.
  - en=1 → SHOW. idx = 0 in auto mode. idx = sel_manual in manual mode if sel_manual < N_CH, else 0.
- SHOW:
  - data_out = data_in[idx]; ch_en = onehot(idx) & ~blank_mask; prescaler increments each cycle.
  - Auto mode, prescaler == DIV-1: idx ← (idx == N_CH-1) ? 0 : idx+1. Prescaler clears. Go to BLANK, or stay in SHOW if BLANK_CYC == 0.
  - Manual mode, sel_manual ≠ idx and sel_manual < N_CH: idx ← sel_manual, prescaler clears, go to BLANK (or stay in SHOW if BLANK_CYC == 0).
  - Manual mode: an out-of-range sel_manual is ignored and idx holds.
  - Manual mode: the prescaler wraps silently with no advance.
- BLANK:
  - ch_en = 0; data_out already shows the new idx's word.
  - A counter runs BLANK_CYC cycles, then the FSM returns to SHOW.
  - sel_manual changes during BLANK are sampled only once the FSM is back in SHOW.
- frame_tick = 1 for exactly the cycle after idx registers a wrap N_CH-1 → 0 in auto mode. Never asserted in manual mode.
- en=0 in any state → IDLE on the next edge, with all outputs and counters cleared as at reset.
- Mode change in SHOW:
  - Auto → manual: takes effect immediately.
  - Manual → auto: scanning resumes from the current idx with the prescaler cleared.
  - A mode change during BLANK is applied on entry to SHOW.
- rst_n low mid-operation: all registers asynchronously return to reset values.

## Timing
- All outputs are registered. Latency from data_in to data_out is 1 cycle in SHOW/BLANK.
- Auto-mode period per channel: DIV + BLANK_CYC cycles. Frame period: N_CH × (DIV + BLANK_CYC).
- From en rising (sampled at edge t): SHOW state, ch_en and data_out valid after edge t+1.
- idx, data_out and the deassertion of ch_en change on the same edge when entering BLANK. ch_en for the new channel asserts on the edge that returns to SHOW.
- No combinational path from any input to any output.

## Structure
- Shared package disp_pkg holds:
  - state encoding constants ST_IDLE, ST_SHOW, ST_BLANK
  - a clog2 helper function, reused by later display blocks
- One sub-module: tick_gen. It is a parametrised modulo-DIV counter with clear and enable inputs and a terminal-count output. It is instantiated once for the SHOW prescaler. The BLANK counter is inline in the FSM.
- Channel select is an indexed part-select of data_in; no per-channel instance.

## Test plan
Default bench parameters: N_CH=3, W=4, DIV=4, BLANK_CYC=2, data_in = {4'hC, 4'hB, 4'hA}.
- Reset, then en=1 auto: idx sequence 0,1,2,0.
  - Each channel has 4 SHOW cycles with ch_en 001/010/100, then 2 cycles of ch_en=000.
  - data_out follows A/B/C.
  - frame_tick pulses once every 18 cycles.
- Non-power-of-two wrap: confirm idx never reaches 3 over 10 frames.
  - Rerun with N_CH=5: wrap 4 → 0 every 30 cycles.
- Manual mode, sel_manual 0 → 2 mid-SHOW:
  - Next edge: idx=2, data_out=C, ch_en=000 for 2 cycles, then 100.
  - sel_manual=3: idx holds at 2 indefinitely, frame_tick stays 0.
- blank_mask=3'b010 in auto: ch_en never asserts bit 1, while data_out still shows B during channel 1's slot.
- BLANK_CYC=0: ch_en changes directly 001 → 010 with no all-zero cycle, and the period is 4 cycles.
- en=0 in BLANK, and separately rst_n low in SHOW:
  - en=0: outputs are 0 on the next edge.
  - rst_n low: outputs are 0 immediately (asynchronously).
  - After either, re-enable starts at idx 0 with a full 4-cycle SHOW.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display-path definitions: scanner state encoding and a constant clog2
// helper for sizing counters and index fields in the display blocks.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } disp_state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter with synchronous clear and count enable; o_tc_c flags
// the last count of each period.
module tick_gen
    import disp_pkg::*;
#(
    parameter  int unsigned DIV = 4,
    localparam int unsigned CW  = (clog2(DIV) > 1) ? clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_tc_c = (r_cnt == LAST);

endmodule

// File: rtl/digit_scan_mux.sv
// Registered N-channel display scanner: cycles (or manually selects) one
// channel word at a time, with a blanking gap on every channel change.
module digit_scan_mux
    import disp_pkg::*;
#(
    parameter  int unsigned N_CH      = 4,
    parameter  int unsigned W         = 4,
    parameter  int unsigned DIV       = 50000,
    parameter  int unsigned BLANK_CYC = 2,
    localparam int unsigned SW        = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [SW-1:0]       sel_manual,
    input  logic [N_CH*W-1:0]   data_in,
    input  logic [N_CH-1:0]     blank_mask,
    output logic [W-1:0]        data_out,
    output logic [N_CH-1:0]     ch_en,
    output logic [SW-1:0]       idx,
    output logic                frame_tick
);

    localparam int unsigned   BW        = (clog2(BLANK_CYC) > 1) ? clog2(BLANK_CYC) : 1;
    localparam logic [SW-1:0] LAST_CH   = SW'(N_CH - 1);
    localparam logic [BW-1:0] LAST_BLK  = BW'(BLANK_CYC - 1);
    localparam bit            HAS_BLANK = (BLANK_CYC != 0);

    disp_state_t   r_state;
    logic [SW-1:0] r_idx;
    logic [BW-1:0] r_bcnt;
    logic          r_mode_q;
    logic [W-1:0]  r_data;
    logic [N_CH-1:0] r_ch_en;
    logic          r_tick;

    disp_state_t   w_state_nxt;
    logic [SW-1:0] w_idx_nxt;
    logic [BW-1:0] w_bcnt_nxt;
    logic          w_mode_q_nxt;
    logic          w_clr;
    logic          w_wrap;
    logic          w_go_new;
    logic          w_sel_ok;
    logic          w_tc;
    logic          w_cnt_en;
    logic [W-1:0]  w_data_nxt;
    logic [N_CH-1:0] w_ch_en_nxt;

    assign w_sel_ok = (32'(sel_manual) < N_CH);
    assign w_cnt_en = (r_state == ST_SHOW);

    tick_gen #(
        .DIV(DIV)
    ) u_prescale (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_cnt_en),
        .o_tc_c (w_tc)
    );

    // Next-state, next-index and counter control.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_bcnt_nxt   = r_bcnt;
        w_mode_q_nxt = 1'b0;
        w_clr        = 1'b1;
        w_wrap       = 1'b0;
        w_go_new     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_SHOW;
                    w_idx_nxt   = (mode && w_sel_ok) ? sel_manual : '0;
                end
            end
            ST_SHOW: begin
                w_clr        = 1'b0;
                w_mode_q_nxt = mode;
                if (mode) begin
                    if (w_sel_ok && (sel_manual != r_idx)) begin
                        w_idx_nxt = sel_manual;
                        w_go_new  = 1'b1;
                    end
                end else if (r_mode_q) begin
                    // First auto cycle after manual: restart the SHOW period.
                    w_clr = 1'b1;
                end else if (w_tc) begin
                    w_wrap    = (r_idx == LAST_CH);
                    w_idx_nxt = w_wrap ? '0 : r_idx + SW'(1);
                    w_go_new  = 1'b1;
                end
                if (w_go_new) begin
                    w_clr = 1'b1;
                    if (HAS_BLANK) begin
                        w_state_nxt  = ST_BLANK;
                        w_bcnt_nxt   = '0;
                        w_mode_q_nxt = 1'b0;
                    end
                end
            end
            ST_BLANK: begin
                if (r_bcnt == LAST_BLK) begin
                    w_state_nxt = ST_SHOW;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_bcnt_nxt = r_bcnt + BW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (!en) begin
            w_state_nxt  = ST_IDLE;
            w_idx_nxt    = '0;
            w_bcnt_nxt   = '0;
            w_mode_q_nxt = 1'b0;
            w_clr        = 1'b1;
            w_wrap       = 1'b0;
        end
    end

    // Outputs are computed from the next index so they move with idx.
    always_comb begin
        w_data_nxt  = '0;
        w_ch_en_nxt = '0;
        if (w_state_nxt != ST_IDLE) begin
            w_data_nxt = data_in[32'(w_idx_nxt) * W +: W];
        end
        if (w_state_nxt == ST_SHOW) begin
            w_ch_en_nxt = (N_CH'(1) << w_idx_nxt) & ~blank_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_bcnt   <= '0;
            r_mode_q <= 1'b0;
            r_data   <= '0;
            r_ch_en  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_mode_q <= w_mode_q_nxt;
            r_data   <= w_data_nxt;
            r_ch_en  <= w_ch_en_nxt;
            r_tick   <= w_wrap;
        end
    end

    assign data_out   = r_data;
    assign ch_en      = r_ch_en;
    assign idx        = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: three instances (3ch/2 blank, 5ch/2 blank,
// 3ch/no blank) checked every cycle against a slot-timing model.
module tb_digit_scan_mux;

    localparam int DIV_T    = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_SHOW  = 1;
    localparam int PH_BLANK = 2;
    localparam int N_OF [3] = '{3, 5, 3};
    localparam int BC_OF[3] = '{2, 2, 0};

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic [1:0]  sel_a;
    logic [2:0]  sel_b;
    logic [11:0] data_a;
    logic [19:0] data_b;
    logic [2:0]  mask_a;
    logic [4:0]  mask_b;

    logic [3:0]  do_a, do_b, do_z;
    logic [2:0]  ce_a, ce_z;
    logic [4:0]  ce_b;
    logic [1:0]  ix_a, ix_z;
    logic [2:0]  ix_b;
    logic        ft_a, ft_b, ft_z;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int m_ph[3], m_idx[3], m_left[3], m_man[3];
    int e_data[3], e_chen[3], e_tick[3];

    always #5 clk = ~clk;

    digit_scan_mux #(.N_CH(3), .W(4), .DIV(4), .BLANK_CYC(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel_a),
        .data_in(data_a), .blank_mask(mask_a), .data_out(do_a), .ch_en(ce_a),
        .idx(ix_a), .frame_tick(ft_a));

    digit_scan_mux #(.N_CH(5), .W(4), .DIV(4), .BLANK_CYC(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel_b),
        .data_in(data_b), .blank_mask(mask_b), .data_out(do_b), .ch_en(ce_b),
        .idx(ix_b), .frame_tick(ft_b));

    digit_scan_mux #(.N_CH(3), .W(4), .DIV(4), .BLANK_CYC(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_manual(sel_a),
        .data_in(data_a), .blank_mask(mask_a), .data_out(do_z), .ch_en(ce_z),
        .idx(ix_z), .frame_tick(ft_z));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int in_sel(input int i);
        return (i == 1) ? int'(sel_b) : int'(sel_a);
    endfunction

    function automatic int in_mask(input int i);
        return (i == 1) ? int'(mask_b) : int'(mask_a);
    endfunction

    function automatic int in_word(input int i, input int k);
        logic [19:0] t;
        t = (i == 1) ? data_b : {8'h00, data_a};
        return int'(t[4*k +: 4]);
    endfunction

    // Slot model: each SHOW lasts DIV cycles, each change costs BC blank cycles.
    task automatic mdl_step(input int i);
        int n, bc, s;
        bit adv;
        n  = N_OF[i];
        bc = BC_OF[i];
        s  = in_sel(i);
        adv = 1'b0;
        e_tick[i] = 0;
        if (!en) begin
            m_ph[i]  = PH_IDLE;
            m_idx[i] = 0;
        end else begin
            case (m_ph[i])
                PH_IDLE: begin
                    m_ph[i]   = PH_SHOW;
                    m_idx[i]  = (mode && s < n) ? s : 0;
                    m_left[i] = DIV_T;
                    m_man[i]  = 0;
                end
                PH_SHOW: begin
                    if (mode) begin
                        m_man[i] = 1;
                        if (s < n && s != m_idx[i]) begin
                            m_idx[i] = s;
                            adv = 1'b1;
                        end
                    end else if (m_man[i] != 0) begin
                        m_man[i]  = 0;
                        m_left[i] = DIV_T;
                    end else if (m_left[i] == 1) begin
                        e_tick[i] = (m_idx[i] == n - 1) ? 1 : 0;
                        m_idx[i]  = (m_idx[i] + 1) % n;
                        adv = 1'b1;
                    end else begin
                        m_left[i]--;
                    end
                    if (adv) begin
                        if (bc > 0) begin
                            m_ph[i]   = PH_BLANK;
                            m_left[i] = bc;
                            m_man[i]  = 0;
                        end else begin
                            m_left[i] = DIV_T;
                        end
                    end
                end
                default: begin
                    if (m_left[i] == 1) begin
                        m_ph[i]   = PH_SHOW;
                        m_left[i] = DIV_T;
                        m_man[i]  = 0;
                    end else begin
                        m_left[i]--;
                    end
                end
            endcase
        end
        e_data[i] = (m_ph[i] == PH_IDLE) ? 0 : in_word(i, m_idx[i]);
        e_chen[i] = (m_ph[i] == PH_SHOW) ?
                    ((1 << m_idx[i]) & ~in_mask(i) & ((1 << n) - 1)) : 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_ph[i] = PH_IDLE; m_idx[i] = 0; m_left[i] = 0; m_man[i] = 0;
                    e_data[i] = 0; e_chen[i] = 0; e_tick[i] = 0;
                end else begin
                    mdl_step(i);
                end
            end
        end
    end

    task automatic cmp_inst(input string tag, input int i, input int ix, input int ce,
                            input int dd, input int ft);
        chk({tag, ".idx"},  ix, m_idx[i]);
        chk({tag, ".chen"}, ce, e_chen[i]);
        chk({tag, ".data"}, dd, e_data[i]);
        chk({tag, ".tick"}, ft, e_tick[i]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("a", 0, int'(ix_a), int'(ce_a), int'(do_a), int'(ft_a));
            cmp_inst("b", 1, int'(ix_b), int'(ce_b), int'(do_b), int'(ft_b));
            cmp_inst("z", 2, int'(ix_z), int'(ce_z), int'(do_z), int'(ft_z));
        end
    end

    task automatic check_a(input string nm, input int ei, input int ec, input int ed, input int et);
        chk({nm, ".a_idx"},  int'(ix_a), ei);
        chk({nm, ".a_chen"}, int'(ce_a), ec);
        chk({nm, ".a_data"}, int'(do_a), ed);
        chk({nm, ".a_tick"}, int'(ft_a), et);
    endtask

    task automatic restart(input bit m);
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1; mode = m;
        @(negedge clk);
    endtask

    initial begin
        int ta, tb, tz;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        sel_a = '0; sel_b = '0; mask_a = '0; mask_b = '0;
        data_a = 12'hCBA; data_b = 20'hEDCBA;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        check_a("reset", 0, 0, 0, 0);

        // Auto scan from enable.
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        check_a("auto_e0", 0, 1, 10, 0);
        chk("auto_e0.z_chen", int'(ce_z), 1);
        chk("auto_e0.b_chen", int'(ce_b), 1);
        repeat (3) @(negedge clk);
        check_a("auto_e3", 0, 1, 10, 0);
        @(negedge clk);
        check_a("auto_e4", 1, 0, 11, 0);
        chk("auto_e4.z_idx", int'(ix_z), 1);
        chk("auto_e4.z_chen", int'(ce_z), 2);
        @(negedge clk);
        check_a("auto_e5", 1, 0, 11, 0);
        @(negedge clk);
        check_a("auto_e6", 1, 2, 11, 0);
        repeat (10) @(negedge clk);
        check_a("auto_e16", 0, 0, 10, 1);
        @(negedge clk);
        check_a("auto_e17", 0, 0, 10, 0);
        repeat (10) @(negedge clk);
        chk("auto_e27.b_idx", int'(ix_b), 4);
        chk("auto_e27.b_tick", int'(ft_b), 0);
        @(negedge clk);
        chk("auto_e28.b_idx", int'(ix_b), 0);
        chk("auto_e28.b_tick", int'(ft_b), 1);
        chk("auto_e28.b_data", int'(do_b), 10);
        chk("auto_e28.z_idx", int'(ix_z), 1);

        // Ten frames of channel a: never index 3, pulse counts per window.
        ta = 0; tb = 0; tz = 0;
        for (int c = 0; c < 180; c++) begin
            @(negedge clk);
            ta += int'(ft_a); tb += int'(ft_b); tz += int'(ft_z);
            chk("a.idx_in_range", (ix_a < 2'd3) ? 1 : 0, 1);
            chk("b.idx_in_range", (ix_b < 3'd5) ? 1 : 0, 1);
        end
        chk("a.frames_180", ta, 10);
        chk("b.frames_180", tb, 6);
        chk("z.frames_180", tz, 15);

        // en=0 while blanking, then re-enable.
        restart(1'b0);
        check_a("re_e0", 0, 1, 10, 0);
        repeat (4) @(negedge clk);
        check_a("re_e4_blank", 1, 0, 11, 0);
        en = 1'b0;
        @(negedge clk);
        check_a("en0_blank", 0, 0, 0, 0);
        en = 1'b1;
        @(negedge clk);
        check_a("en1_e0", 0, 1, 10, 0);
        repeat (3) @(negedge clk);
        check_a("en1_e3", 0, 1, 10, 0);
        @(negedge clk);
        check_a("en1_e4", 1, 0, 11, 0);

        // Asynchronous reset in SHOW.
        repeat (3) @(negedge clk);
        check_a("pre_rst", 1, 2, 11, 0);
        #2 rst_n = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 0, 0);
        chk("async_rst.b_chen", int'(ce_b), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_a("rst_e0", 0, 1, 10, 0);
        repeat (3) @(negedge clk);
        check_a("rst_e3", 0, 1, 10, 0);
        @(negedge clk);
        check_a("rst_e4", 1, 0, 11, 0);

        // Manual select 0 -> 2, then out-of-range request.
        sel_a = 2'd0;
        restart(1'b1);
        check_a("man_e0", 0, 1, 10, 0);
        repeat (2) @(negedge clk);
        sel_a = 2'd2;
        @(negedge clk);
        check_a("man_e3", 2, 0, 12, 0);
        chk("man_e3.z_idx", int'(ix_z), 2);
        chk("man_e3.z_chen", int'(ce_z), 4);
        @(negedge clk);
        check_a("man_e4", 2, 0, 12, 0);
        @(negedge clk);
        check_a("man_e5", 2, 4, 12, 0);
        sel_a = 2'd3;
        repeat (20) @(negedge clk);
        check_a("man_hold", 2, 4, 12, 0);

        // Blank mask on channel 1 in auto.
        mask_a = 3'b010;
        restart(1'b0);
        check_a("mask_e0", 0, 1, 10, 0);
        repeat (6) @(negedge clk);
        check_a("mask_e6", 1, 0, 11, 0);
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            chk("a.mask_bit1", int'(ce_a[1]), 0);
        end
        mask_a = '0;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            en = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) begin
                sel_a = 2'($urandom);
                sel_b = 3'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                mask_a = 3'($urandom);
                mask_b = 5'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                data_a = 12'($urandom);
                data_b = 20'($urandom);
            end
            if (rst_n && $urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
